// File: rtl/nivel_pkg.sv
// Shared types for the level-sensor filter: level codes, FSM states and
// the classification of a filtered (alto, baixo) probe pair.
package nivel_pkg;

    typedef enum logic [1:0] {
        NIVEL_ALTO   = 2'b00,
        NIVEL_NORMAL = 2'b01,
        NIVEL_BAIXO  = 2'b10,
        DESCALIBRADO = 2'b11
    } nivel_t;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        SUSPECT,
        FAULT
    } state_t;

    typedef struct packed {
        logic   consistent;
        nivel_t code;
    } class_t;

    localparam int NUM_SENSORS = 2;
    localparam int SENS_BAIXO  = 0;
    localparam int SENS_ALTO   = 1;

    // High probe wet with low probe dry is physically impossible.
    function automatic class_t classify(input logic alto, input logic baixo);
        class_t c;
        c.consistent = 1'b1;
        unique case ({alto, baixo})
            2'b11:   c.code = NIVEL_ALTO;
            2'b01:   c.code = NIVEL_NORMAL;
            2'b00:   c.code = NIVEL_BAIXO;
            default: begin
                c.code       = DESCALIBRADO;
                c.consistent = 1'b0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchronizer followed by a counter debounce for one raw probe.
module debounce_bit
    import nivel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_2,
    input  logic reset,
    input  logic raw,
    output logic filt
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync_q;
    logic [7:0] cnt;

    // cnt never exceeds CNT_LAST: it clears on agreement or on the toggle.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            sync_q <= '0;
            cnt    <= '0;
            filt   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_q[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= ~filt;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/nivel_sensor_filter.sv
// Tank level classifier: debounced high/low probes feed a fault-tolerant FSM
// that drives a 2-bit level code for the 7-segment decoder.
module nivel_sensor_filter
    import nivel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FAULT_CYCLES    = 8
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       sensor_alto,
    input  logic       sensor_baixo,
    input  logic       fault_clear,
    output logic [1:0] nivel,
    output logic       nivel_valid,
    output logic       nivel_change,
    output logic       fault
);

    localparam logic [8:0] INIT_LAST  = 9'(DEBOUNCE_CYCLES + 1);
    localparam logic [7:0] FAULT_LAST = 8'(FAULT_CYCLES - 1);

    logic [NUM_SENSORS-1:0] raw;
    logic [NUM_SENSORS-1:0] filt;
    class_t                 cls;
    state_t                 state;
    nivel_t                 nivel_q;
    logic [8:0]             init_cnt;
    logic [7:0]             fault_cnt;

    assign raw = {sensor_alto, sensor_baixo};

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_sens
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_2(clk_2),
            .reset(reset),
            .raw  (raw[i]),
            .filt (filt[i])
        );
    end

    assign cls   = classify(filt[SENS_ALTO], filt[SENS_BAIXO]);
    assign nivel = nivel_q;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state        <= INIT;
            nivel_q      <= NIVEL_BAIXO;
            nivel_valid  <= 1'b0;
            nivel_change <= 1'b0;
            fault        <= 1'b0;
            init_cnt     <= '0;
            fault_cnt    <= '0;
        end else begin
            nivel_change <= 1'b0;
            unique case (state)
                // Wait for the synchronizers and debouncers to settle.
                INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        fault_cnt <= '0;
                        if (cls.consistent) begin
                            state       <= RUN;
                            nivel_q     <= cls.code;
                            nivel_valid <= 1'b1;
                        end else begin
                            state <= SUSPECT;
                        end
                    end else begin
                        init_cnt <= init_cnt + 9'd1;
                    end
                end
                RUN: begin
                    if (cls.consistent) begin
                        nivel_q      <= cls.code;
                        nivel_change <= (cls.code != nivel_q);
                    end else begin
                        state     <= SUSPECT;
                        fault_cnt <= '0;
                    end
                end
                // nivel holds its last good value while a fault is suspected.
                SUSPECT: begin
                    if (cls.consistent) begin
                        state        <= RUN;
                        nivel_q      <= cls.code;
                        nivel_valid  <= 1'b1;
                        nivel_change <= nivel_valid && (cls.code != nivel_q);
                    end else if (fault_cnt == FAULT_LAST) begin
                        state        <= FAULT;
                        nivel_q      <= DESCALIBRADO;
                        nivel_valid  <= 1'b1;
                        nivel_change <= nivel_valid && (nivel_q != DESCALIBRADO);
                        fault        <= 1'b1;
                    end else begin
                        fault_cnt <= fault_cnt + 8'd1;
                    end
                end
                FAULT: begin
                    if (fault_clear && cls.consistent) begin
                        state        <= RUN;
                        nivel_q      <= cls.code;
                        nivel_change <= 1'b1;
                        fault        <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_nivel_sensor_filter.sv
// Directed bench for nivel_sensor_filter with DEBOUNCE_CYCLES=4, FAULT_CYCLES=8.
module tb_nivel_sensor_filter;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       sensor_alto;
    logic       sensor_baixo;
    logic       fault_clear;
    logic [1:0] nivel;
    logic       nivel_valid;
    logic       nivel_change;
    logic       fault;

    int n_cmp = 0;
    int n_err = 0;

    nivel_sensor_filter #(
        .DEBOUNCE_CYCLES(4),
        .FAULT_CYCLES   (8)
    ) dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .sensor_alto (sensor_alto),
        .sensor_baixo(sensor_baixo),
        .fault_clear (fault_clear),
        .nivel       (nivel),
        .nivel_valid (nivel_valid),
        .nivel_change(nivel_change),
        .fault       (fault)
    );

    always #5 clk_2 = ~clk_2;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        sensor_alto  = 1'b0;
        sensor_baixo = 1'b0;
        fault_clear  = 1'b0;
        tick(1);
        check("rst_nivel", 4'(nivel), 4'h2);
        check("rst_valid", 4'(nivel_valid), 4'h0);
        check("rst_change", 4'(nivel_change), 4'h0);
        check("rst_fault", 4'(fault), 4'h0);

        // Settle with both probes dry: valid after 6 edges, no change pulse.
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            check("init_change", 4'(nivel_change), 4'h0);
            if (i < 6) check("init_valid_lo", 4'(nivel_valid), 4'h0);
            else begin
                check("init_valid_hi", 4'(nivel_valid), 4'h1);
                check("init_nivel", 4'(nivel), 4'h2);
            end
        end

        // Low probe wets: nivel 10 -> 01 on the 7th edge.
        sensor_baixo = 1'b1;
        tick(6);
        check("step_before", 4'(nivel), 4'h2);
        check("step_before_chg", 4'(nivel_change), 4'h0);
        tick(1);
        check("step_nivel", 4'(nivel), 4'h1);
        check("step_change", 4'(nivel_change), 4'h1);
        tick(1);
        check("step_change_end", 4'(nivel_change), 4'h0);
        check("step_hold", 4'(nivel), 4'h1);

        // Three-cycle glitch on the high probe is filtered out.
        sensor_alto = 1'b1;
        tick(3);
        sensor_alto = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("glitch_nivel", 4'(nivel), 4'h1);
            check("glitch_change", 4'(nivel_change), 4'h0);
        end

        // Inconsistent pair: 6 edges to filter, 1 to enter SUSPECT, 8 in SUSPECT.
        sensor_alto  = 1'b1;
        sensor_baixo = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            check("susp_nivel", 4'(nivel), 4'h1);
            check("susp_fault", 4'(fault), 4'h0);
        end
        tick(1);
        check("fault_nivel", 4'(nivel), 4'h3);
        check("fault_flag", 4'(fault), 4'h1);
        check("fault_change", 4'(nivel_change), 4'h1);
        check("fault_valid", 4'(nivel_valid), 4'h1);
        tick(1);
        check("fault_change_end", 4'(nivel_change), 4'h0);

        // Clear request while still inconsistent is ignored.
        fault_clear = 1'b1;
        tick(3);
        check("clr_ignored", 4'(fault), 4'h1);
        check("clr_ign_nivel", 4'(nivel), 4'h3);

        // Restore a consistent pair with clear held: exit on the 7th edge.
        sensor_baixo = 1'b1;
        tick(6);
        check("clr_wait", 4'(fault), 4'h1);
        tick(1);
        check("clr_nivel", 4'(nivel), 4'h0);
        check("clr_fault", 4'(fault), 4'h0);
        check("clr_change", 4'(nivel_change), 4'h1);
        fault_clear = 1'b0;
        tick(1);
        check("clr_change_end", 4'(nivel_change), 4'h0);

        // Back to normal level.
        sensor_alto = 1'b0;
        tick(7);
        check("norm_nivel", 4'(nivel), 4'h1);
        check("norm_change", 4'(nivel_change), 4'h1);

        // Inconsistency lasting 5 filtered cycles does not fault.
        sensor_alto  = 1'b1;
        sensor_baixo = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i == 5) begin
                sensor_alto  = 1'b0;
                sensor_baixo = 1'b1;
            end
            tick(1);
            check("short_nivel", 4'(nivel), 4'h1);
            check("short_fault", 4'(fault), 4'h0);
            check("short_change", 4'(nivel_change), 4'h0);
        end

        // Enter FAULT again, then reset overrides a simultaneous clear.
        sensor_alto  = 1'b1;
        sensor_baixo = 1'b0;
        tick(15);
        check("refault", 4'(fault), 4'h1);
        reset       = 1'b1;
        fault_clear = 1'b1;
        tick(1);
        check("frst_nivel", 4'(nivel), 4'h2);
        check("frst_fault", 4'(fault), 4'h0);
        check("frst_valid", 4'(nivel_valid), 4'h0);
        check("frst_change", 4'(nivel_change), 4'h0);
        reset       = 1'b0;
        fault_clear = 1'b0;
        tick(6);
        check("frst_revalid", 4'(nivel_valid), 4'h1);
        check("frst_renivel", 4'(nivel), 4'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
